// File: rtl/key_evt_queue_pkg.sv
// key_evt_queue_pkg: shared event-word layout, key status encodings and one-cold decode helper
package key_evt_queue_pkg;
    localparam int EVT_W        = 8;
    localparam int EVT_LONG_BIT = 7;
    localparam int EVT_CODE_MSB = 4;
    localparam int EVT_CODE_LSB = 0;
    localparam int N_ROWS       = 6;
    localparam int N_COLS       = 5;
    localparam int MAX_CODE     = 29;

    typedef enum logic [1:0] {
        STA_SHORT = 2'b00,
        STA_LONG  = 2'b11
    } key_sta_e;

    // Returns {exactly_one_zero, index_of_zero}; narrower vectors are padded with 1s.
    function automatic logic [3:0] cold_decode(input logic [N_ROWS-1:0] v);
        logic [2:0] idx;
        logic [2:0] zeros;
        idx   = '0;
        zeros = '0;
        for (int i = 0; i < N_ROWS; i++)
            if (!v[i]) begin
                idx   = 3'(i);
                zeros = zeros + 3'd1;
            end
        return {zeros == 3'd1, idx};
    endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous FIFO of event words with push/pop and full/empty flags
module key_evt_fifo
    import key_evt_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             CLK_LOW,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [EVT_W-1:0] din,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = cnt == '0;
        full    = cnt == (AW+1)'(DEPTH);
        do_pop  = pop & ~empty;
        // a full FIFO still takes a word when the head leaves on the same edge
        do_push = push & (~full | do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge CLK_LOW)
        if (do_push)
            mem[wr_ptr] <= din;

    always_ff @(posedge CLK_LOW) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/key_evt_queue.sv
// key_evt_queue: detects key-scanner events, decodes row/column to a key code and queues them
module key_evt_queue
    import key_evt_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             CLK_LOW,
    input  logic             RST,
    input  logic             KEY_INT,
    input  logic [1:0]       KEY_STA,
    input  logic [N_COLS-1:0] COLUM,
    input  logic [N_ROWS-1:0] ROW,
    output logic [EVT_W-1:0] EVT_DATA,
    output logic             EVT_VALID,
    input  logic             EVT_READY,
    output logic             EVT_IRQ,
    output logic             OVF,
    input  logic             OVF_CLR,
    output logic [7:0]       BAD_CNT
);
    logic              key_prev;
    logic              cap_vld;
    logic [1:0]        cap_sta;
    logic [N_COLS-1:0] cap_col;
    logic [N_ROWS-1:0] cap_row;
    logic              dec_vld;
    logic [EVT_W-1:0]  dec_word;
    logic [3:0]        row_dec;
    logic [3:0]        col_dec;
    logic              evt_ok;
    logic [EVT_W-1:0]  word;
    logic              full;
    logic              empty;
    logic              ovf_set;

    always_comb begin
        row_dec = cold_decode(cap_row);
        col_dec = cold_decode({1'b1, cap_col});
        evt_ok  = row_dec[3] & col_dec[3] & (cap_sta == STA_SHORT || cap_sta == STA_LONG);
        word    = '0;
        word[EVT_LONG_BIT] = cap_sta == STA_LONG;
        word[EVT_CODE_MSB:EVT_CODE_LSB] = {2'b00, row_dec[2:0]} * 5'd5 + {2'b00, col_dec[2:0]};
        // full implies a valid head, so READY alone tells whether the head leaves
        ovf_set = dec_vld & full & ~EVT_READY;
    end

    always_ff @(posedge CLK_LOW) begin
        if (RST) begin
            key_prev <= 1'b0;
            cap_vld  <= 1'b0;
            cap_sta  <= '0;
            cap_col  <= '0;
            cap_row  <= '0;
            dec_vld  <= 1'b0;
            dec_word <= '0;
            OVF      <= 1'b0;
            BAD_CNT  <= '0;
        end else begin
            key_prev <= KEY_INT;
            cap_vld  <= KEY_INT & ~key_prev;
            cap_sta  <= KEY_STA;
            cap_col  <= COLUM;
            cap_row  <= ROW;
            dec_vld  <= cap_vld & evt_ok;
            dec_word <= word;
            OVF      <= ovf_set | (OVF & ~OVF_CLR);
            if (cap_vld && !evt_ok && BAD_CNT != 8'hFF)
                BAD_CNT <= BAD_CNT + 8'd1;
        end
    end

    key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK_LOW (CLK_LOW),
        .RST     (RST),
        .push    (dec_vld),
        .pop     (EVT_READY),
        .din     (dec_word),
        .dout    (EVT_DATA),
        .full    (full),
        .empty   (empty)
    );

    assign EVT_VALID = ~empty;
    assign EVT_IRQ   = EVT_VALID;
endmodule

// File: tb/tb_key_evt_queue.sv
// tb_key_evt_queue: scoreboard bench for key_evt_queue
module tb_key_evt_queue;
    logic       CLK_LOW = 1'b0;
    logic       RST = 1'b1;
    logic       KEY_INT = 1'b0;
    logic [1:0] KEY_STA = 2'b00;
    logic [4:0] COLUM = 5'h1F;
    logic [5:0] ROW = 6'h3F;
    logic [7:0] EVT_DATA;
    logic       EVT_VALID;
    logic       EVT_READY = 1'b0;
    logic       EVT_IRQ;
    logic       OVF;
    logic       OVF_CLR = 1'b0;
    logic [7:0] BAD_CNT;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_popped = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] mon_exp;

    always #5 CLK_LOW = ~CLK_LOW;

    key_evt_queue #(.DEPTH(8)) dut (
        .CLK_LOW   (CLK_LOW),
        .RST       (RST),
        .KEY_INT   (KEY_INT),
        .KEY_STA   (KEY_STA),
        .COLUM     (COLUM),
        .ROW       (ROW),
        .EVT_DATA  (EVT_DATA),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_IRQ   (EVT_IRQ),
        .OVF       (OVF),
        .OVF_CLR   (OVF_CLR),
        .BAD_CNT   (BAD_CNT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_LOW);
        #1;
    endtask

    function automatic logic [5:0] rsel(input int r);
        return ~(6'd1 << r);
    endfunction

    function automatic logic [4:0] csel(input int c);
        return ~(5'd1 << c);
    endfunction

    function automatic logic [7:0] word(input int r, input int c, input bit lng);
        return {lng, 2'b00, 5'(r * 5 + c)};
    endfunction

    task automatic send(input logic [1:0] sta, input logic [5:0] row, input logic [4:0] col, input int width);
        KEY_STA = sta;
        ROW     = row;
        COLUM   = col;
        KEY_INT = 1'b1;
        repeat (width) tick();
        KEY_INT = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain(input string tag, input int n);
        n_popped  = 0;
        EVT_READY = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++)
            tick();
        EVT_READY = 1'b0;
        tick();
        check({tag, "_pops"}, 32'(n_popped), 32'(n));
        check({tag, "_empty"}, 32'(EVT_VALID), 32'd0);
        check({tag, "_idle_data"}, 32'(EVT_DATA), 32'd0);
    endtask

    // Consumer side: each accepted head must match the oldest expected word
    always @(negedge CLK_LOW)
        if (!RST && EVT_VALID && EVT_READY) begin
            n_popped++;
            mon_exp = exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
            check("pop_data", 32'(EVT_DATA), mon_exp);
        end

    initial begin
        repeat (3) tick();
        check("rst_valid", 32'(EVT_VALID), 32'd0);
        check("rst_data", 32'(EVT_DATA), 32'd0);
        check("rst_irq", 32'(EVT_IRQ), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_bad", 32'(BAD_CNT), 32'd0);
        RST = 1'b0;
        tick();

        // long pulse, exact latency
        KEY_STA = 2'b00; ROW = 6'b111011; COLUM = 5'b11101; KEY_INT = 1'b1;
        exp_q.push_back(8'h0B);
        tick();
        tick();
        check("lat_k1_valid", 32'(EVT_VALID), 32'd0);
        tick();
        check("lat_k2_valid", 32'(EVT_VALID), 32'd1);
        check("lat_k2_data", 32'(EVT_DATA), 32'h0B);
        check("lat_k2_irq", 32'(EVT_IRQ), 32'd1);
        repeat (197) tick();
        KEY_INT = 1'b0;
        tick();
        drain("long_pulse", 1);

        exp_q.push_back(8'h9D);
        send(2'b11, 6'b011111, 5'b01111, 3);
        drain("long_press", 1);

        // illegal events
        send(2'b00, 6'b000000, 5'b00000, 1);
        check("bad_zero_cnt", 32'(BAD_CNT), 32'd1);
        check("bad_zero_valid", 32'(EVT_VALID), 32'd0);
        send(2'b01, 6'b111011, 5'b11101, 1);
        check("bad_sta01", 32'(BAD_CNT), 32'd2);
        send(2'b10, 6'b111110, 5'b10111, 1);
        check("bad_sta10", 32'(BAD_CNT), 32'd3);
        send(2'b00, 6'b110011, 5'b11110, 1);
        check("bad_two_rows", 32'(BAD_CNT), 32'd4);
        check("bad_valid", 32'(EVT_VALID), 32'd0);

        // fill and overflow
        for (int i = 0; i < 9; i++) begin
            if (i < 8)
                exp_q.push_back(word(i % 6, (i + 2) % 5, i[0]));
            send(i[0] ? 2'b11 : 2'b00, rsel(i % 6), csel((i + 2) % 5), 1);
        end
        check("ovf_set", 32'(OVF), 32'd1);
        check("full_valid", 32'(EVT_VALID), 32'd1);

        // overflow on the same edge as a clear keeps OVF set
        OVF_CLR = 1'b1;
        KEY_STA = 2'b00; ROW = rsel(4); COLUM = csel(4); KEY_INT = 1'b1;
        tick();
        KEY_INT = 1'b0;
        tick();
        check("ovf_clr_k1", 32'(OVF), 32'd0);
        tick();
        OVF_CLR = 1'b0;
        check("ovf_wins_clr", 32'(OVF), 32'd1);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("ovf_clr_pulse", 32'(OVF), 32'd0);

        // push coinciding with pop on a full FIFO
        exp_q.push_back(word(5, 0, 1'b1));
        KEY_STA = 2'b11; ROW = rsel(5); COLUM = csel(0); KEY_INT = 1'b1;
        tick();
        KEY_INT = 1'b0;
        tick();
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        check("coinc_ovf", 32'(OVF), 32'd0);
        check("coinc_valid", 32'(EVT_VALID), 32'd1);
        tick();
        check("coinc_ovf_late", 32'(OVF), 32'd0);
        drain("full_drain", 8);

        // reset one cycle after the edge discards the event
        KEY_STA = 2'b00; ROW = rsel(1); COLUM = csel(3); KEY_INT = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        KEY_INT = 1'b0;
        tick();
        RST = 1'b0;
        check("rstmid_valid", 32'(EVT_VALID), 32'd0);
        check("rstmid_bad", 32'(BAD_CNT), 32'd0);
        repeat (5) tick();
        check("rstmid_valid_late", 32'(EVT_VALID), 32'd0);

        // KEY_INT already high at reset release counts as a fresh edge
        RST = 1'b1;
        KEY_STA = 2'b11; ROW = rsel(3); COLUM = csel(2); KEY_INT = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        exp_q.push_back(word(3, 2, 1'b1));
        repeat (4) tick();
        check("rel_high_valid", 32'(EVT_VALID), 32'd1);
        KEY_INT = 1'b0;
        drain("rel_high", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/key_evt_queue.md
KEY_EVT_QUEUE -- requirements
Module: key_evt_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 4..32).
REQ-002 SHALL have port CLK_LOW  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port KEY_INT  input  1  key-event pulse from key scanner, high for multiple cycles.
REQ-005 SHALL have port KEY_STA  input  2  event type: 2'b00 short press, 2'b11 long press, others illegal.
REQ-006 SHALL have port COLUM  input  5  captured column, active-low one-cold.
REQ-007 SHALL have port ROW  input  6  captured row drive, active-low one-cold.
REQ-008 SHALL have port EVT_DATA  output  8  head event word {LONG, 2'b00, CODE[4:0]}.
REQ-009 SHALL have port EVT_VALID  output  1  head entry present.
REQ-010 SHALL have port EVT_READY  input  1  consumer accepts head when high with EVT_VALID.
REQ-011 SHALL have port EVT_IRQ  output  1  level interrupt, equals FIFO not-empty.
REQ-012 SHALL have port OVF  output  1  sticky overflow flag.
REQ-013 SHALL have port OVF_CLR  input  1  clears OVF.
REQ-014 SHALL have port BAD_CNT  output  8  saturating count of rejected events.

Function
REQ-015 SHALL detect event as KEY_INT high at edge k and low at edge k-1 (registered previous value); one event per KEY_INT pulse regardless of width.
REQ-016 SHALL sample KEY_STA, COLUM, ROW at edge k (same edge as detection).
REQ-017 SHALL decode row_idx = bit position of the single 0 in ROW (0..5), col_idx = bit position of the single 0 in COLUM (0..4); CODE = row_idx*5 + col_idx (0..29), 5 bits.
REQ-018 SHALL reject event if ROW or COLUM has not exactly one zero bit (incl. all-0/all-1) or KEY_STA is 01/10; rejected events not queued, BAD_CNT += 1, saturating at 255.
REQ-019 SHALL set LONG = 1 for KEY_STA 2'b11, 0 for 2'b00.
REQ-020 SHALL register decoded word at edge k+1 and push into FIFO at edge k+2; with empty FIFO EVT_VALID high after edge k+2.
REQ-021 SHALL pop head on edge where EVT_VALID & EVT_READY; EVT_DATA/EVT_VALID hold stable while EVT_VALID & !EVT_READY.
REQ-022 SHALL, when FIFO full and push and pop coincide, accept both; count unchanged.
REQ-023 SHALL, when FIFO full and push without pop, drop new event, keep contents, set OVF.
REQ-024 SHALL clear OVF when OVF_CLR high; an overflow in the same cycle wins (OVF stays 1).
REQ-025 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-026 SHALL present EVT_DATA = 8'h00 when EVT_VALID low.
REQ-027 SHALL drive EVT_IRQ combinationally equal to EVT_VALID.

Reset
REQ-028 SHALL, on RST high at a clock edge, empty FIFO, clear pointers, pipeline stage, KEY_INT history, OVF=0, BAD_CNT=0, EVT_VALID=0, EVT_DATA=0.
REQ-029 SHALL discard any event in the decode pipeline when RST asserts mid-operation; KEY_INT history resets to 0, so a KEY_INT already high at reset release counts as a new edge.

Structure
REQ-030 SHALL place in shared package: event word field positions, KEY_STA encodings (SHORT=00, LONG=11), row count 6, column count 5, max CODE 29.
REQ-031 SHALL instantiate one sub-module key_evt_fifo (synchronous FIFO, push/pop/full/empty, parameter DEPTH); edge detect and decode stay in top.

Verification
REQ-032 SHALL cover: ROW=6'b111011, COLUM=5'b11101, KEY_STA=00, KEY_INT 200-cycle pulse -> one entry EVT_DATA=8'h0B, EVT_VALID high 2 cycles after edge, EVT_IRQ=1.
REQ-033 SHALL cover: ROW=6'b011111, COLUM=5'b01111, KEY_STA=11 -> EVT_DATA=8'h9D.
REQ-034 SHALL cover: ROW=6'b000000, COLUM=5'b00000 (cleared values) -> no entry, BAD_CNT=1; KEY_STA=01 valid row/col -> BAD_CNT=2.
REQ-035 SHALL cover: 9 valid events, EVT_READY=0, DEPTH=8 -> 8 entries, 9th dropped, OVF=1; OVF_CLR pulse -> OVF=0; drain order equals push order.
REQ-036 SHALL cover: full FIFO, push coinciding with pop -> occupancy stays 8, OVF stays 0, new event last out.
REQ-037 SHALL cover: RST asserted one cycle after KEY_INT edge -> EVT_VALID=0, no entry after release until next KEY_INT edge.
